dmem_responder: RTL

Data-memory responder for the RV32I core's load/store port. It accepts one request at a time over a valid/ready handshake and performs byte, halfword or word access on an internal word-organised RAM. Load data is sign- or zero-extended according to funct3. Latency is configurable and includes wait states. The response is returned over a second valid/ready handshake and carries an error flag.

---
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port.
// One request at a time: IDLE -> WAIT (optional) -> READ -> ACCESS -> RESP.
// The RAM has a synchronous read port, so READ fetches the addressed word and
// ACCESS extracts load data or commits the store through per-byte enables.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;
    logic [AW-1:0] idx;

    logic        acc_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_en;

    assign idx       = addr_q[AW+1:2];
    assign req_ready = (state_q == S_IDLE) && reset;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Classify the latched request and build load data / store lane enables.
    always_comb begin
        acc_err = 1'b0;
        if (f3_q == 3'b011 || f3_q[2:1] == 2'b11) acc_err = 1'b1;
        if (f3_q[1:0] == 2'b01 && addr_q[0]) acc_err = 1'b1;
        if (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) acc_err = 1'b1;
        if ({2'b00, addr_q[31:2]} >= DEPTH_WORDS) acc_err = 1'b1;
        if (we_q && f3_q[2]) acc_err = 1'b1;

        case (addr_q[1:0])
            2'd0:    byte_sel = rd_word_q[7:0];
            2'd1:    byte_sel = rd_word_q[15:8];
            2'd2:    byte_sel = rd_word_q[23:16];
            default: byte_sel = rd_word_q[31:24];
        endcase
        half_sel = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

        case (f3_q)
            3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_data = {24'd0, byte_sel};
            3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_data = {16'd0, half_sel};
            3'b010:  ld_data = rd_word_q;
            default: ld_data = 32'd0;
        endcase
        if (acc_err || we_q) ld_data = 32'd0;

        case (f3_q[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata_q;
            end
        endcase

        // A reset sampled on the ACCESS edge drops the store.
        wr_en = (state_q == S_ACCESS) && we_q && !acc_err && reset;
    end

    // Next-state logic for the request/response FSM and its latched fields.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_READ : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) state_d = S_READ;
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            S_READ: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                rdata_d = ld_data;
                err_d   = acc_err;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM array: synchronous read in READ, byte-enabled write in ACCESS; never reset.
    always_ff @(posedge clk) begin
        if (state_q == S_READ) begin
            rd_word_q <= mem[idx];
        end
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule
